// File: rtl/dac_update_scheduler_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dac_update_scheduler_if                                                    |
// | Bundle between the four channel requesters, the DAC serializer and the     |
// | dac_update_scheduler.                                                      |
// |   req_i/data_i/ack_o        : per-channel request, data, accept pulse      |
// |   ldac_mode_i/frame_trig_i  : LDAC policy select and frame load strobe     |
// |   word_o/word_valid_o/      : 24-bit DAC command word handshake            |
// |   word_ready_i/ser_busy_i     towards the serializer                       |
// |   dacLoad                   : LDAC, active low                             |
// |   pend_o/dbg_state          : written-not-loaded channels, FSM state       |
// | master = scheduler side, slave = requesters/serializer side.               |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
interface dac_update_scheduler_if;
  logic [3:0]  req_i;
  logic [63:0] data_i;
  logic [3:0]  ack_o;
  logic        ldac_mode_i;
  logic        frame_trig_i;
  logic [23:0] word_o;
  logic        word_valid_o;
  logic        word_ready_i;
  logic        ser_busy_i;
  logic        dacLoad;
  logic [3:0]  pend_o;
  logic [2:0]  dbg_state;

  modport master (
    input  req_i, data_i, ldac_mode_i, frame_trig_i, word_ready_i, ser_busy_i,
    output ack_o, word_o, word_valid_o, dacLoad, pend_o, dbg_state
  );

  modport slave (
    output req_i, data_i, ldac_mode_i, frame_trig_i, word_ready_i, ser_busy_i,
    input  ack_o, word_o, word_valid_o, dacLoad, pend_o, dbg_state
  );
endinterface
`default_nettype wire

// File: rtl/dac_update_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dac_update_scheduler                                                       |
// | Shares one AD5754-class DAC between four requesters: round-robin picks a   |
// | pending channel, builds the 24-bit write word, hands it to the serializer  |
// | over valid/ready, enforces the SYNC guard time and drives the LDAC pulse   |
// | either after every word (mode 0) or on a frame trigger (mode 1).           |
// | Ports:                                                                     |
// |   clk     : system clock, rising edge                                      |
// |   Reset_n : asynchronous active-low reset                                  |
// |   bus     : dac_update_scheduler_if.master (requests, word handshake,      |
// |             LDAC, pending mask, debug state)                               |
// | Parameters: GUARD_CYCLES >= 1, LDAC_WIDTH in 1..15.                        |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module dac_update_scheduler #(
  parameter int N_CH         = 4,
  parameter int GUARD_CYCLES = 2,
  parameter int LDAC_WIDTH   = 4
) (
  input  logic                          clk,
  input  logic                          Reset_n,
  dac_update_scheduler_if.master        bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARB       = 3'd1,
    ISSUE     = 3'd2,
    WAIT_BUSY = 3'd3,
    GUARD     = 3'd4,
    LOAD      = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [1:0]  ptr;
  logic [1:0]  sel;
  logic [23:0] word;
  logic [3:0]  pend;
  logic        trig_pend;
  logic [7:0]  guard_cnt;
  logic [3:0]  ldac_cnt;
  logic        busy_skip;   // set from the second WAIT_BUSY cycle onwards

  logic        found;
  logic [1:0]  pick;
  logic [1:0]  idx;
  logic        handshake;
  logic        guard_done;
  logic        load_done;
  logic        trig_live;

  // Round-robin search starting at ptr, wrapping 3 -> 0.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    idx   = ptr;
    for (int i = 0; i < N_CH; i++) begin
      idx = ptr + 2'(i);
      if (!found && bus.req_i[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  assign handshake  = (state == ISSUE) && bus.word_ready_i;
  assign guard_done = (guard_cnt == 8'(GUARD_CYCLES - 1));
  assign load_done  = (ldac_cnt == 4'(LDAC_WIDTH - 1));
  // A stored trigger only matters while frame mode is selected.
  assign trig_live  = trig_pend && bus.ldac_mode_i;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    bus.word_valid_o = 1'b0;
    bus.ack_o        = 4'b0000;
    bus.dacLoad      = 1'b1;
    case (state)
      IDLE: begin
        if (trig_live && (pend != 4'b0000)) begin
          state_nxt = LOAD;
        end else if (trig_live) begin
          state_nxt = IDLE;           // trigger with nothing pending is dropped
        end else if (bus.req_i != 4'b0000) begin
          state_nxt = ARB;
        end
      end
      ARB: begin
        state_nxt = found ? ISSUE : IDLE;
      end
      ISSUE: begin
        bus.word_valid_o = 1'b1;
        if (bus.word_ready_i) begin
          bus.ack_o = 4'b0001 << sel;
          state_nxt = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (busy_skip && !bus.ser_busy_i) begin
          state_nxt = GUARD;
        end
      end
      GUARD: begin
        if (guard_done) begin
          state_nxt = bus.ldac_mode_i ? IDLE : LOAD;
        end
      end
      LOAD: begin
        bus.dacLoad = 1'b0;
        if (load_done) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      ptr       <= 2'd0;
      sel       <= 2'd0;
      word      <= 24'd0;
      pend      <= 4'b0000;
      trig_pend <= 1'b0;
      guard_cnt <= 8'd0;
      ldac_cnt  <= 4'd0;
      busy_skip <= 1'b0;
    end else begin
      // The LOAD exit clear wins so a trigger during LOAD is absorbed by it.
      // In IDLE a stale trigger is dropped (mode 0 or nothing pending), but a
      // strobe arriving in that same cycle is kept.
      if ((state == LOAD) && load_done) begin
        trig_pend <= 1'b0;
      end else if ((state == IDLE) && (!bus.ldac_mode_i || (pend == 4'b0000))) begin
        trig_pend <= bus.frame_trig_i && bus.ldac_mode_i;
      end else if (bus.frame_trig_i && bus.ldac_mode_i) begin
        trig_pend <= 1'b1;
      end

      if ((state == ARB) && found) begin
        sel  <= pick;
        word <= {6'b000000, pick, bus.data_i[{pick, 4'b0000} +: 16]};
      end

      if (handshake) begin
        pend[sel] <= 1'b1;
        ptr       <= sel + 2'd1;
      end else if ((state == LOAD) && load_done) begin
        pend <= 4'b0000;
      end

      // Low only in the first WAIT_BUSY cycle, giving busy time to rise.
      busy_skip <= (state == WAIT_BUSY);
      guard_cnt <= (state == GUARD) ? guard_cnt + 8'd1 : 8'd0;
      ldac_cnt  <= (state == LOAD)  ? ldac_cnt + 4'd1  : 4'd0;
    end
  end

  assign bus.word_o    = word;
  assign bus.pend_o    = pend;
  assign bus.dbg_state = state;

endmodule
`default_nettype wire
